// File: rtl/logistic_sweep_sequencer_pkg.sv
// Shared constants, FSM state type and the row-extraction helper used by the
// logistic-map bifurcation sweep sequencer.
//   X_W       state x width (fixed-point format of the function unit)
//   MU_W      mu width
//   CNT_W     warm-up / plot counter width
//   COORD_W   pixel column/row width
//   ROW_SHIFT row = x >> ROW_SHIFT
package logistic_sweep_sequencer_pkg;

  localparam int unsigned X_W       = 17;
  localparam int unsigned MU_W      = 18;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned ROW_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARM,
    PLOT,
    NEXT,
    FIN
  } sweep_state_t;

  // Plot row for a state value, zero-extended to the coordinate width.
  function automatic logic [COORD_W-1:0] row_of(input logic [X_W-1:0] x);
    logic [X_W-1:0] s;
    s = x >> ROW_SHIFT;
    return s[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/logistic_sweep_sequencer_if.sv
// Pixel request handshake from the sweep sequencer to the frame-buffer writer.
//   px_valid  pixel request valid (master -> slave)
//   px_ready  writer accepts the pixel (slave -> master)
//   px_col    pixel column
//   px_row    pixel row
interface logistic_sweep_sequencer_if;
  import logistic_sweep_sequencer_pkg::*;

  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] px_col;
  logic [COORD_W-1:0] px_row;

  modport master (output px_valid, output px_col, output px_row, input px_ready);
  modport slave  (input px_valid, input px_col, input px_row, output px_ready);

endinterface

// File: rtl/logistic_sweep_sequencer_mu_gen.sv
// Column counter and mu accumulator for the sweep.
//   CLK, RST     clock / synchronous active-low reset
//   load_i       start of sweep: column 0, mu = mu_start_i, latch mu_step_i
//   step_i       advance to next column: col+1, mu += latched step (mod 2^MU_W)
//   mu_start_i   mu for column 0
//   mu_step_i    mu increment per column
//   col_o        current column
//   mu_o         current mu (registered, drives the function unit directly)
//   last_o       current column is COLS-1
module logistic_sweep_sequencer_mu_gen
  import logistic_sweep_sequencer_pkg::*;
#(
  parameter int unsigned COLS = 640
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [MU_W-1:0]    mu_start_i,
  input  logic [MU_W-1:0]    mu_step_i,
  output logic [COORD_W-1:0] col_o,
  output logic [MU_W-1:0]    mu_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(COLS - 1);

  logic [COORD_W-1:0] col_q;
  logic [MU_W-1:0]    mu_q;
  logic [MU_W-1:0]    step_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      col_q  <= '0;
      mu_q   <= '0;
      step_q <= '0;
    end else if (load_i) begin
      col_q  <= '0;
      mu_q   <= mu_start_i;
      step_q <= mu_step_i;
    end else if (step_i) begin
      col_q  <= col_q + COORD_W'(1);
      mu_q   <= mu_q + step_q;
    end
  end

  assign col_o  = col_q;
  assign mu_o   = mu_q;
  assign last_o = (col_q == LAST_COL);

endmodule

// File: rtl/logistic_sweep_sequencer.sv
// Sequences an external combinational logistic-map unit to draw a bifurcation
// diagram: per column, reload x from the seed, run `warmup` discarded
// iterations, then emit `plot_n` pixels (col, x >> ROW_SHIFT).
//   CLK, RST   clock / synchronous active-low reset
//   start      begin a sweep (sampled only in IDLE)
//   mu_start   mu for column 0 (latched on start)
//   mu_step    mu increment per column (latched on start)
//   seed       initial x for every column (latched on start)
//   warmup     discarded iterations per column (latched on start)
//   plot_n     plotted iterations per column (latched on start)
//   fn_x       x operand to the function unit (registered)
//   fn_mu      mu operand to the function unit (registered)
//   fn_y       function result, combinational from fn_x/fn_mu
//   px         pixel handshake (master side)
//   busy       sweep in progress
//   done       one-cycle pulse when the sweep completes
module logistic_sweep_sequencer
  import logistic_sweep_sequencer_pkg::*;
#(
  parameter int unsigned COLS = 640
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [MU_W-1:0]              mu_start,
  input  logic [MU_W-1:0]              mu_step,
  input  logic [X_W-1:0]               seed,
  input  logic [CNT_W-1:0]             warmup,
  input  logic [CNT_W-1:0]             plot_n,
  output logic [X_W-1:0]               fn_x,
  output logic [MU_W-1:0]              fn_mu,
  input  logic [X_W-1:0]               fn_y,
  logistic_sweep_sequencer_if.master   px,
  output logic                         busy,
  output logic                         done
);

  sweep_state_t       state_q;
  logic [X_W-1:0]     fn_x_q;
  logic [X_W-1:0]     seed_q;
  logic [CNT_W-1:0]   warm_q;
  logic [CNT_W-1:0]   plot_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]   pcnt_q;
  logic               valid_q;
  logic [COORD_W-1:0] px_col_q;
  logic [COORD_W-1:0] px_row_q;
  logic               busy_q;
  logic               done_q;

  logic               mu_load;
  logic               mu_step_en;
  logic [COORD_W-1:0] col;
  logic               last_col;

  assign mu_load    = (state_q == IDLE) && start;
  assign mu_step_en = (state_q == NEXT) && !last_col;

  logistic_sweep_sequencer_mu_gen #(
    .COLS (COLS)
  ) u_mu_gen (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (mu_load),
    .step_i     (mu_step_en),
    .mu_start_i (mu_start),
    .mu_step_i  (mu_step),
    .col_o      (col),
    .mu_o       (fn_mu),
    .last_o     (last_col)
  );

  // px_row is updated together with fn_x so the row always reflects the
  // operand currently presented, without a combinational path to the port.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      fn_x_q   <= '0;
      seed_q   <= '0;
      warm_q   <= '0;
      plot_q   <= '0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      valid_q  <= 1'b0;
      px_col_q <= '0;
      px_row_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            seed_q  <= seed;
            warm_q  <= warmup;
            plot_q  <= plot_n;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          fn_x_q   <= seed_q;
          px_row_q <= row_of(seed_q);
          wcnt_q   <= '0;
          pcnt_q   <= '0;
          if (warm_q != '0) begin
            state_q <= WARM;
          end else if (plot_q != '0) begin
            state_q  <= PLOT;
            valid_q  <= 1'b1;
            px_col_q <= col;
          end else begin
            state_q <= NEXT;
          end
        end
        WARM: begin
          fn_x_q   <= fn_y;
          px_row_q <= row_of(fn_y);
          wcnt_q   <= wcnt_q + CNT_W'(1);
          if (wcnt_q == warm_q - CNT_W'(1)) begin
            if (plot_q != '0) begin
              state_q  <= PLOT;
              valid_q  <= 1'b1;
              px_col_q <= col;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        PLOT: begin
          if (valid_q && px.px_ready) begin
            fn_x_q   <= fn_y;
            px_row_q <= row_of(fn_y);
            pcnt_q   <= pcnt_q + CNT_W'(1);
            if (pcnt_q == plot_q - CNT_W'(1)) begin
              valid_q <= 1'b0;
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          if (last_col) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= LOAD;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fn_x        = fn_x_q;
  assign px.px_valid = valid_q;
  assign px.px_col   = px_col_q;
  assign px.px_row   = px_row_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
